// File: rtl/spi_rx_word_framer_if.sv
// Pin-side bundle for the SPI receive framer: CS/MOSI in, published word/status out.
// Latency: n/a (wiring only). Backpressure: none; words are announced by a toggle strobe.
// master drives the SPI pins and observes results; slave is the framer itself.
interface spi_rx_word_framer_if #(
    parameter int BIT_PER_TRANSFER = 18,
    parameter int IDX_W            = 8
);
    logic                        i_SPI_CS_n;
    logic                        i_SPI_MOSI;
    logic [BIT_PER_TRANSFER-1:0] o_Word;
    logic                        o_Word_Tgl;
    logic [IDX_W-1:0]            o_Word_Idx;
    logic                        o_Frame_Err;
    logic [5:0]                  o_Err_Bits;
    logic                        o_Parity_Err;

    modport master (
        output i_SPI_CS_n, i_SPI_MOSI,
        input  o_Word, o_Word_Tgl, o_Word_Idx, o_Frame_Err, o_Err_Bits, o_Parity_Err
    );

    modport slave (
        input  i_SPI_CS_n, i_SPI_MOSI,
        output o_Word, o_Word_Tgl, o_Word_Idx, o_Frame_Err, o_Err_Bits, o_Parity_Err
    );
endinterface

// File: rtl/spi_rx_word_framer.sv
// SPI-clock-domain MOSI word framer with per-frame word index, toggle strobe and partial-frame error.
// Latency: word/toggle update on the edge sampling the last bit. Backpressure: none (toggle strobe).
// Optional odd-parity check on each word when SPI_RX_PARITY_EN is defined.
module spi_rx_word_framer #(
    parameter int BIT_PER_TRANSFER = 18,
    parameter int IDX_W            = 8
) (
    input  logic                 w_SPI_Clk,
    input  logic                 i_Rst_L,
    spi_rx_word_framer_if.slave  bus
);
    localparam int         N        = BIT_PER_TRANSFER;
    localparam logic [5:0] LAST_BIT = 6'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic cs_n, mosi;
    assign cs_n = bus.i_SPI_CS_n;
    assign mosi = bus.i_SPI_MOSI;

    state_e           state_q, state_d;
    logic             r_New_Frame_q, r_New_Frame_d;
    logic [N-1:0]     r_Shift_q, r_Shift_d;
    logic [5:0]       r_Bit_Cnt_q, r_Bit_Cnt_d;
    logic [IDX_W-1:0] r_Idx_q, r_Idx_d;
    logic [N-1:0]     o_Word_q, o_Word_d;
    logic             o_Word_Tgl_q, o_Word_Tgl_d;
    logic [IDX_W-1:0] o_Word_Idx_q, o_Word_Idx_d;
    logic             o_Frame_Err_q, o_Frame_Err_d;
    logic [5:0]       o_Err_Bits_q, o_Err_Bits_d;
`ifdef SPI_RX_PARITY_EN
    logic             o_Parity_Err_q, o_Parity_Err_d;
`endif

    assign state_q       = r_New_Frame_q ? IDLE : SHIFT;
    assign r_New_Frame_d = (state_d == IDLE);

    // The SPI clock may be stopped between frames, so CS high must arm IDLE without it.
    always_ff @(posedge w_SPI_Clk or posedge cs_n or negedge i_Rst_L) begin
        if (!i_Rst_L)
            r_New_Frame_q <= 1'b1;
        else if (cs_n)
            r_New_Frame_q <= 1'b1;
        else
            r_New_Frame_q <= r_New_Frame_d;
    end

    always_comb begin
        state_d        = state_q;
        r_Shift_d      = r_Shift_q;
        r_Bit_Cnt_d    = r_Bit_Cnt_q;
        r_Idx_d        = r_Idx_q;
        o_Word_d       = o_Word_q;
        o_Word_Tgl_d   = o_Word_Tgl_q;
        o_Word_Idx_d   = o_Word_Idx_q;
        o_Frame_Err_d  = o_Frame_Err_q;
        o_Err_Bits_d   = o_Err_Bits_q;
`ifdef SPI_RX_PARITY_EN
        o_Parity_Err_d = o_Parity_Err_q;
`endif
        if (!cs_n) begin
            state_d   = SHIFT;
            r_Shift_d = {r_Shift_q[N-2:0], mosi};
            if (state_q == IDLE) begin
                // Leftover bits from the previous frame are only visible now.
                o_Frame_Err_d = (r_Bit_Cnt_q != 6'd0);
                o_Err_Bits_d  = r_Bit_Cnt_q;
                r_Idx_d       = '0;
                r_Bit_Cnt_d   = 6'd1;
            end else if (r_Bit_Cnt_q == LAST_BIT) begin
                o_Word_d     = r_Shift_d;
                o_Word_Idx_d = r_Idx_q;
                o_Word_Tgl_d = ~o_Word_Tgl_q;
                r_Idx_d      = r_Idx_q + 1'b1;
                r_Bit_Cnt_d  = 6'd0;
`ifdef SPI_RX_PARITY_EN
                o_Parity_Err_d = ~^r_Shift_d;
`endif
            end else begin
                r_Bit_Cnt_d = r_Bit_Cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Shift_q      <= '0;
            r_Bit_Cnt_q    <= '0;
            r_Idx_q        <= '0;
            o_Word_q       <= '0;
            o_Word_Tgl_q   <= 1'b0;
            o_Word_Idx_q   <= '0;
            o_Frame_Err_q  <= 1'b0;
            o_Err_Bits_q   <= '0;
`ifdef SPI_RX_PARITY_EN
            o_Parity_Err_q <= 1'b0;
`endif
        end else begin
            r_Shift_q      <= r_Shift_d;
            r_Bit_Cnt_q    <= r_Bit_Cnt_d;
            r_Idx_q        <= r_Idx_d;
            o_Word_q       <= o_Word_d;
            o_Word_Tgl_q   <= o_Word_Tgl_d;
            o_Word_Idx_q   <= o_Word_Idx_d;
            o_Frame_Err_q  <= o_Frame_Err_d;
            o_Err_Bits_q   <= o_Err_Bits_d;
`ifdef SPI_RX_PARITY_EN
            o_Parity_Err_q <= o_Parity_Err_d;
`endif
        end
    end

    assign bus.o_Word      = o_Word_q;
    assign bus.o_Word_Tgl  = o_Word_Tgl_q;
    assign bus.o_Word_Idx  = o_Word_Idx_q;
    assign bus.o_Frame_Err = o_Frame_Err_q;
    assign bus.o_Err_Bits  = o_Err_Bits_q;
`ifdef SPI_RX_PARITY_EN
    assign bus.o_Parity_Err = o_Parity_Err_q;
`else
    assign bus.o_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_rx_word_framer.sv
// Directed bench for spi_rx_word_framer: single/multi-word frames, partial-frame error,
// index wrap over 257 words, mid-frame reset and parity (expected value follows SPI_RX_PARITY_EN).
module tb_spi_rx_word_framer;
    localparam int N     = 18;
    localparam int IDX_W = 8;

    logic w_SPI_Clk = 1'b0;
    logic i_Rst_L   = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   tgl_cnt   = 0;
    logic exp_tgl   = 1'b0;

    spi_rx_word_framer_if #(.BIT_PER_TRANSFER(N), .IDX_W(IDX_W)) bus ();

    spi_rx_word_framer #(.BIT_PER_TRANSFER(N), .IDX_W(IDX_W)) dut (
        .w_SPI_Clk (w_SPI_Clk),
        .i_Rst_L   (i_Rst_L),
        .bus       (bus.slave)
    );

    always #5 w_SPI_Clk = ~w_SPI_Clk;

    always @(posedge bus.o_Word_Tgl or negedge bus.o_Word_Tgl) tgl_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge w_SPI_Clk);
            bus.i_SPI_CS_n = 1'b0;
            bus.i_SPI_MOSI = v[i];
            @(posedge w_SPI_Clk);
            #1;
        end
    endtask

    task automatic cs_high();
        @(negedge w_SPI_Clk);
        bus.i_SPI_CS_n = 1'b1;
        bus.i_SPI_MOSI = 1'b0;
        repeat (3) @(posedge w_SPI_Clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] w, input logic [31:0] idx);
        exp_tgl = ~exp_tgl;
        chk({tag, "_word"}, 32'(bus.o_Word), w);
        chk({tag, "_idx"}, 32'(bus.o_Word_Idx), idx);
        chk({tag, "_tgl"}, 32'(bus.o_Word_Tgl), 32'(exp_tgl));
    endtask

    initial begin
        logic exp_par3;
`ifdef SPI_RX_PARITY_EN
        exp_par3 = 1'b1;
`else
        exp_par3 = 1'b0;
`endif
        bus.i_SPI_CS_n = 1'b1;
        bus.i_SPI_MOSI = 1'b0;
        repeat (3) @(posedge w_SPI_Clk);
        #1;
        chk("rst_word", 32'(bus.o_Word), 0);
        chk("rst_tgl", 32'(bus.o_Word_Tgl), 0);
        chk("rst_idx", 32'(bus.o_Word_Idx), 0);
        chk("rst_ferr", 32'(bus.o_Frame_Err), 0);
        chk("rst_ebits", 32'(bus.o_Err_Bits), 0);
        chk("rst_par", 32'(bus.o_Parity_Err), 0);
        @(negedge w_SPI_Clk);
        i_Rst_L = 1'b1;
        repeat (2) @(posedge w_SPI_Clk);
        #1;

        // Single word; toggle must not move before the 18th edge.
        send_bits(32'h2A5A5 >> 1, 17);
        chk("w1_tgl_early", 32'(bus.o_Word_Tgl), 0);
        send_bits(32'h2A5A5, 1);
        chk_word("w1", 32'h2A5A5, 0);
        chk("w1_ferr", 32'(bus.o_Frame_Err), 0);
        cs_high();

        // Three back-to-back words
        send_bits(32'h00001, 18);
        chk_word("m0", 32'h00001, 0);
        chk("m0_ferr", 32'(bus.o_Frame_Err), 0);
        send_bits(32'h3FFFF, 18);
        chk_word("m1", 32'h3FFFF, 1);
        send_bits(32'h15555, 18);
        chk_word("m2", 32'h15555, 2);
        cs_high();
        chk("m_hold_word", 32'(bus.o_Word), 32'h15555);
        chk("m_hold_idx", 32'(bus.o_Word_Idx), 2);

        // 25-bit frame leaves 7 bits behind
        send_bits(32'h0ABCD, 18);
        chk_word("p0", 32'h0ABCD, 0);
        send_bits(32'h55, 7);
        cs_high();
        chk("p_ferr_held", 32'(bus.o_Frame_Err), 0);
        // CS glitch with no clocks in between must not change anything
        @(negedge w_SPI_Clk);
        bus.i_SPI_CS_n = 1'b0;
        #1;
        bus.i_SPI_CS_n = 1'b1;
        #1;
        send_bits(32'h12345 >> 17, 1);
        chk("p_ferr", 32'(bus.o_Frame_Err), 1);
        chk("p_ebits", 32'(bus.o_Err_Bits), 7);
        send_bits(32'h12345, 17);
        chk_word("p1", 32'h12345, 0);
        chk("p1_ferr", 32'(bus.o_Frame_Err), 1);
        cs_high();

        // 257 words: index wraps 255 -> 0
        tgl_cnt = 0;
        for (int k = 0; k < 257; k++) begin
            send_bits(32'(k * 3 + 7), 18);
            exp_tgl = ~exp_tgl;
            chk("wrap_idx", 32'(bus.o_Word_Idx), 32'(k % 256));
            chk("wrap_word", 32'(bus.o_Word), 32'(k * 3 + 7));
        end
        chk("wrap_ferr", 32'(bus.o_Frame_Err), 0);
        chk("wrap_tgl_cnt", 32'(tgl_cnt), 257);
        cs_high();

        // Reset mid-word after 9 bits
        send_bits(32'h1FF, 9);
        i_Rst_L = 1'b0;
        #2;
        exp_tgl = 1'b0;
        chk("mr_word", 32'(bus.o_Word), 0);
        chk("mr_tgl", 32'(bus.o_Word_Tgl), 0);
        chk("mr_idx", 32'(bus.o_Word_Idx), 0);
        chk("mr_ferr", 32'(bus.o_Frame_Err), 0);
        chk("mr_ebits", 32'(bus.o_Err_Bits), 0);
        chk("mr_par", 32'(bus.o_Parity_Err), 0);
        cs_high();
        i_Rst_L = 1'b1;
        repeat (2) @(posedge w_SPI_Clk);
        #1;
        send_bits(32'h0000F, 18);
        chk_word("ar", 32'h0000F, 0);
        chk("ar_ferr", 32'(bus.o_Frame_Err), 0);
        chk("ar_ebits", 32'(bus.o_Err_Bits), 0);
        cs_high();

        // Parity: 0x00001 has odd parity, 0x00003 even
        send_bits(32'h00001, 18);
        chk_word("par0", 32'h00001, 0);
        chk("par_odd", 32'(bus.o_Parity_Err), 0);
        send_bits(32'h00003, 18);
        chk_word("par1", 32'h00003, 1);
        chk("par_even", 32'(bus.o_Parity_Err), 32'(exp_par3));
        cs_high();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_rx_word_framer.md
# spi_rx_word_framer

SPI-clock-domain receive framer that sits directly on the MOSI/CS pins, ahead of the clock-domain crossing into the i_Clk fabric. It shifts MOSI bits into BIT_PER_TRANSFER-bit words and numbers each word within its CS-low frame. It publishes every completed word with a toggle strobe, so the i_Clk side can detect words with a 2-FF synchroniser even when the SPI clock stops after the last word. It also flags frames that end on a partial word.

## Interface
- BIT_PER_TRANSFER, 18, word length in bits (4..32); MSB first on MOSI.
- IDX_W, 8, width of the word index within a frame.
- w_SPI_Clk  in  1  SPI clock; rising edge samples MOSI (mode 0, CPOL=0/CPHA=0).
- i_Rst_L  in  1  reset, asynchronous, active-low; clock w_SPI_Clk.
- i_SPI_CS_n  in  1  chip select, active low; a rising edge asynchronously arms frame-start.
- i_SPI_MOSI  in  1  serial data.
- o_Word  out  BIT_PER_TRANSFER  last completed word; held until the next word completes.
- o_Word_Tgl  out  1  toggles once per completed word.
- o_Word_Idx  out  IDX_W  index of o_Word within its frame; first word = 0.
- o_Frame_Err  out  1  set when a frame ended with 1..BIT_PER_TRANSFER-1 leftover bits.
- o_Err_Bits  out  6  leftover bit count of the errored frame.
- o_Parity_Err  out  1  parity error on o_Word; constant 0 when SPI_RX_PARITY_EN is undefined.

## Operation
- Internal state:
  - r_Shift, BIT_PER_TRANSFER bits.
  - r_Bit_Cnt, 6 bits, range 0..BIT_PER_TRANSFER-1.
  - r_Idx, IDX_W bits.
  - r_New_Frame, a flag set asynchronously by i_Rst_L low or by a rising edge on i_SPI_CS_n, and cleared synchronously.
- States, decoded from the flags:
  - IDLE: r_New_Frame=1.
  - SHIFT: r_New_Frame=0, CS low.
- Every posedge w_SPI_Clk with i_SPI_CS_n=1: no state change. Clocks outside a frame are ignored.
- Posedge with CS low in IDLE (first bit of a frame):
  - If r_Bit_Cnt!=0: o_Frame_Err<=1 and o_Err_Bits<=r_Bit_Cnt.
  - If r_Bit_Cnt==0: o_Frame_Err<=0 and o_Err_Bits<=0.
  - In both cases: r_Idx<=0, r_Bit_Cnt<=1, r_Shift<={r_Shift[N-2:0],MOSI}, clear r_New_Frame.
- Posedge with CS low in SHIFT: shift in MOSI and increment r_Bit_Cnt.
- Word completion: when the shifted-in bit is bit N-1 (r_Bit_Cnt==N-1 before the edge), on the same edge:
  - o_Word<={r_Shift[N-2:0],MOSI}, o_Word_Idx<=r_Idx.
  - o_Word_Tgl<=~o_Word_Tgl.
  - r_Idx<=r_Idx+1 (wraps modulo 2^IDX_W), r_Bit_Cnt<=0.
- Completion on the very first bit of a frame (only possible if N==1) is not supported; N>=4.
- Back-to-back words within a frame need no gap. Bit N+1 is bit 0 of the next word.
- Boundary cases:
  - CS rises mid-word: the partial bits are held. The error is reported at the first clock of the next frame, because the SPI clock is not running in between.
  - CS glitch with no clocks: IDLE is re-armed and nothing else changes.
  - i_Rst_L low mid-frame, all regs reset:
    - o_Word=0, o_Word_Tgl=0, o_Word_Idx=0, o_Frame_Err=0, o_Err_Bits=0, o_Parity_Err=0.
    - r_Bit_Cnt=0, r_Idx=0, r_Shift=0, r_New_Frame=1.
  - The first frame after reset therefore never reports an error.

## Timing
- Latency: o_Word and o_Word_Tgl update on the same rising edge that samples the last bit of the word.
- o_Word and o_Word_Idx are stable from that edge until at least N SPI clocks later. The i_Clk side must therefore sample o_Word within N SPI periods of seeing the synchronised toggle. With i_Clk ≥4× SPI clock and 18-bit words this has wide margin.
- o_Frame_Err and o_Err_Bits update on the first rising edge of the next frame and hold for the whole frame.
- All outputs are registered, with no combinational path from the pins.

## Configuration
- SPI_RX_PARITY_EN defined:
  - On each word completion, o_Parity_Err<=~^{word}, i.e. 1 when the 18-bit word (17-bit payload plus bit 0 parity) does not have odd parity.
  - o_Parity_Err updates together with o_Word.
- SPI_RX_PARITY_EN undefined: no parity logic is built and o_Parity_Err is tied to 0.

## Test plan
- Reset, then one frame carrying 0x2A5A5 (18 bits) -> o_Word=0x2A5A5, o_Word_Idx=0, o_Word_Tgl 0->1 on the 18th rising edge, o_Frame_Err=0.
- One frame of 3 words 0x00001, 0x3FFFF, 0x15555 -> three toggles, o_Word_Idx=0,1,2 with matching o_Word; after CS rises, outputs hold 0x15555/idx 2.
- Frame of 25 bits, then a new frame of 18 bits 0x12345 -> first frame gives one word; at the first edge of the second frame o_Frame_Err=1, o_Err_Bits=7, o_Word_Idx=0 at its word.
- 257 words in one frame with IDX_W=8 -> o_Word_Idx runs 255 then 0; the toggle count equals 257.
- i_Rst_L pulsed low after 9 bits of a word -> all outputs 0 immediately; the next frame of 0x0000F produces o_Word=0x0000F, idx 0, no error.
- With SPI_RX_PARITY_EN: send 0x00001 (odd) -> o_Parity_Err=0; send 0x00003 (even) -> o_Parity_Err=1. Without the macro, o_Parity_Err=0 for both.
